dram_row_cmd_sequencer: RTL
===========================

Name: dram_row_cmd_sequencer

Overview:
- Per-bank command sequencer that sits between the request front end and the row-open tracker.
- Samples the tracker's 2-bit row status (00 IDLE, 01 HIT, 10 MISS, 11 CONFLICT) and issues the PRE/ACT/RD/WR/REF command sequence the status requires, honouring tRP, tRCD and tRFC.
- Drives the tracker's req_en, refresh and row_resolve inputs.
- Uses an open-page policy: a row stays open after access until a conflict or a refresh.

Parameters:
- T_RCD, 4, cycles from ACT issue to RD/WR issue (min 1).
- T_RP, 4, cycles from PRE issue to ACT/REF issue (min 1).
- T_RFC, 16, cycles from REF issue until the sequencer returns to IDLE (min 1).
- CNT_W, 5, wait-counter width; must hold max(T_RCD, T_RP, T_RFC).

Ports:
- CLK, input, 1, clock.
- nRST, input, 1, reset; synchronous, active-low.
- req_valid, input, 1, request pending; held stable until req_ready.
- req_write, input, 1, 1 = write, 0 = read; stable while req_valid.
- req_ready, output, 1, one-cycle pulse in the cycle RD/WR is issued (request consumed).
- refresh_req, input, 1, refresh needed; held until refresh_ack.
- refresh_ack, output, 1, one-cycle pulse in the cycle REF is issued.
- row_stat, input, 2, tracker status for the current request.
- ro_req_en, output, 1, request enable to tracker.
- ro_refresh, output, 1, refresh notice to tracker.
- ro_row_resolve, output, 1, row-opened notice to tracker.
- cmd_valid, output, 1, command strobe.
- cmd, output, 3, 0 NOP, 1 ACT, 2 PRE, 3 RD, 4 WR, 5 REF.

Behaviour:
- Reset (nRST low at a clock edge):
  - State goes to IDLE; counter and the internal row_open flag clear.
  - All outputs are 0; cmd = NOP.
  - Reset applied mid-sequence abandons that sequence with no further commands.
- States: IDLE, PRE, PRE_WAIT, ACT, ACT_WAIT, RW, REF, REF_WAIT.
- Outputs are Moore, decoded from state:
  - PRE: cmd = PRE, cmd_valid = 1.
  - ACT: cmd = ACT, cmd_valid = 1, ro_row_resolve = 1.
  - RW: cmd = RD or WR per req_write, cmd_valid = 1, req_ready = 1.
  - REF: cmd = REF, cmd_valid = 1, ro_refresh = 1, refresh_ack = 1.
  - All other states: cmd = NOP, cmd_valid = 0.
- ro_req_en = req_valid & (state == IDLE) & ~refresh_req. Combinational; row_stat is sampled in the same cycle.
- IDLE priority: refresh_req beats req_valid.
  - refresh_req with row_open = 1 -> PRE; with row_open = 0 -> REF.
  - Otherwise, if req_valid: row_stat HIT -> RW; MISS -> ACT; CONFLICT -> PRE.
  - row_stat IDLE (00) with req_valid is treated as not resolved: stay in IDLE, no command.
- Every command state lasts exactly one cycle.
  - PRE -> PRE_WAIT, loads counter T_RP-1, clears row_open. If T_RP = 1, skip the wait state.
  - PRE_WAIT counts down to 0, then goes to REF if the sequence is a refresh, else ACT. A latched pending-refresh bit records which.
  - ACT -> ACT_WAIT (counter T_RCD-1) -> RW; sets row_open.
  - RW -> IDLE.
  - REF -> REF_WAIT (counter T_RFC-1) -> IDLE.
- Resulting issue cycles, with the IDLE sampling cycle = cycle 0:
  - HIT: RD/WR at cycle 1.
  - MISS: ACT at 1, RD/WR at 1+T_RCD.
  - CONFLICT: PRE at 1, ACT at 1+T_RP, RD/WR at 1+T_RP+T_RCD.
  - Refresh, row closed: REF at 1, IDLE again at 1+T_RFC.
  - Refresh, row open: PRE at 1, REF at 1+T_RP.
- Once a sequence starts, changes on req_valid, row_stat and refresh_req are ignored until the sequencer returns to IDLE. Refresh is never inserted mid-access.
- At most one cmd_valid per cycle. The minimum gap between back-to-back requests is one IDLE cycle.
- The counter decrements saturating at 0; no wrap-around.

Test Plan:
- HIT read: req_valid=1, req_write=0, row_stat=01 at cycle 0 -> cmd=RD, cmd_valid=1, req_ready=1 at cycle 1; IDLE and cmd=NOP at cycle 2.
- MISS write (T_RCD=4): row_stat=10 -> ACT and ro_row_resolve at cycle 1; NOP cycles 2-4; WR and req_ready at cycle 5.
- CONFLICT read (T_RP=4, T_RCD=4): row_stat=11 -> PRE at 1, ACT at 5, RD at 9. Check exactly three cmd_valid pulses.
- Refresh with row open, asserted together with req_valid (after a prior MISS access): ro_req_en=0.
  - Required: PRE at 1; REF with ro_refresh=1 and refresh_ack=1 at 5; IDLE at 21 (T_RFC=16).
  - The request is then served: with row_stat=10, ACT at 22.
- Refresh with row closed (directly after reset): REF at cycle 1, no PRE.
- Reset mid-sequence: deassert nRST during ACT_WAIT -> all outputs 0 next cycle, no RD issued. A following refresh issues REF directly, confirming row_open was cleared.

Source files
------------

// File: rtl/dram_row_cmd_sequencer.sv
// Per-bank DRAM command sequencer: turns tracker row status into PRE/ACT/RD/WR/REF
// sequences with tRP/tRCD/tRFC spacing, open-page policy.
module dram_row_cmd_sequencer #(
   parameter int unsigned T_RCD = 4,
   parameter int unsigned T_RP  = 4,
   parameter int unsigned T_RFC = 16,
   parameter int unsigned CNT_W = 5
) (
   input  logic       CLK,
   input  logic       nRST,
   input  logic       req_valid,
   input  logic       req_write,
   output logic       req_ready,
   input  logic       refresh_req,
   output logic       refresh_ack,
   input  logic [1:0] row_stat,
   output logic       ro_req_en,
   output logic       ro_refresh,
   output logic       ro_row_resolve,
   output logic       cmd_valid,
   output logic [2:0] cmd
);

   typedef enum logic [2:0] {
      StIdle, StPre, StPreWait, StAct, StActWait, StRw, StRef, StRefWait
   } state_e;

   localparam logic [2:0] CmdNop = 3'd0;
   localparam logic [2:0] CmdAct = 3'd1;
   localparam logic [2:0] CmdPre = 3'd2;
   localparam logic [2:0] CmdRd  = 3'd3;
   localparam logic [2:0] CmdWr  = 3'd4;
   localparam logic [2:0] CmdRef = 3'd5;

   localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);
   localparam logic [CNT_W-1:0] RpLoad  = CNT_W'(T_RP - 1);
   localparam logic [CNT_W-1:0] RcdLoad = CNT_W'(T_RCD - 1);
   localparam logic [CNT_W-1:0] RfcLoad = CNT_W'(T_RFC - 1);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             row_open_q, row_open_d;
   logic             ref_pend_q, ref_pend_d;

   always_ff @(posedge CLK) begin
      if (!nRST) begin
         state_q    <= StIdle;
         cnt_q      <= '0;
         row_open_q <= 1'b0;
         ref_pend_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         row_open_q <= row_open_d;
         ref_pend_q <= ref_pend_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = (cnt_q != '0) ? cnt_q - CntOne : '0;
      row_open_d = row_open_q;
      ref_pend_d = ref_pend_q;

      case (state_q)
         StIdle: begin
            cnt_d = '0;
            if (refresh_req) begin
               ref_pend_d = 1'b1;
               state_d    = row_open_q ? StPre : StRef;
            end else if (req_valid) begin
               ref_pend_d = 1'b0;
               case (row_stat)
                  2'b01:   state_d = StRw;
                  2'b10:   state_d = StAct;
                  2'b11:   state_d = StPre;
                  default: state_d = StIdle; // tracker not resolved yet
               endcase
            end
         end
         StPre: begin
            row_open_d = 1'b0;
            if (T_RP == 1) begin
               state_d = ref_pend_q ? StRef : StAct;
            end else begin
               cnt_d   = RpLoad;
               state_d = StPreWait;
            end
         end
         StPreWait: begin
            // Leave on the last wait cycle so the next command lands exactly T_RP after PRE
            if (cnt_q <= CntOne) state_d = ref_pend_q ? StRef : StAct;
         end
         StAct: begin
            row_open_d = 1'b1;
            if (T_RCD == 1) begin
               state_d = StRw;
            end else begin
               cnt_d   = RcdLoad;
               state_d = StActWait;
            end
         end
         StActWait: begin
            if (cnt_q <= CntOne) state_d = StRw;
         end
         StRw: begin
            state_d = StIdle;
         end
         StRef: begin
            ref_pend_d = 1'b0;
            if (T_RFC == 1) begin
               state_d = StIdle;
            end else begin
               cnt_d   = RfcLoad;
               state_d = StRefWait;
            end
         end
         StRefWait: begin
            if (cnt_q <= CntOne) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      cmd            = CmdNop;
      cmd_valid      = 1'b0;
      req_ready      = 1'b0;
      refresh_ack    = 1'b0;
      ro_refresh     = 1'b0;
      ro_row_resolve = 1'b0;
      ro_req_en      = req_valid & (state_q == StIdle) & ~refresh_req;

      unique case (state_q)
         StPre: begin
            cmd       = CmdPre;
            cmd_valid = 1'b1;
         end
         StAct: begin
            cmd            = CmdAct;
            cmd_valid      = 1'b1;
            ro_row_resolve = 1'b1;
         end
         StRw: begin
            cmd       = req_write ? CmdWr : CmdRd;
            cmd_valid = 1'b1;
            req_ready = 1'b1;
         end
         StRef: begin
            cmd         = CmdRef;
            cmd_valid   = 1'b1;
            ro_refresh  = 1'b1;
            refresh_ack = 1'b1;
         end
         default: ;
      endcase
   end

endmodule
